// File: rtl/blake2_msg_sched_if.sv
// Config, byte-stream, core-side and digest signals of the blake2 message scheduler.
// The slave modport is the scheduler; master is whatever surrounds it.
interface blake2_msg_sched_if #(
  parameter int W    = 32,
  parameter int BB   = W*2,
  parameter int KK_W = $clog2(W+1)
);
  localparam int IDX_W = $clog2(BB);

  logic             cfg_v_i;
  logic             cfg_ready_o;
  logic [KK_W-1:0]  cfg_kk_i;
  logic [KK_W-1:0]  cfg_nn_i;
  logic [BB-1:0]    cfg_ll_i;
  logic             s_v_i;
  logic             s_ready_o;
  logic [7:0]       s_data_i;
  logic             core_data_v_o;
  logic [IDX_W-1:0] core_data_idx_o;
  logic [7:0]       core_data_o;
  logic             core_first_o;
  logic             core_last_o;
  logic [KK_W-1:0]  core_kk_o;
  logic [KK_W-1:0]  core_nn_o;
  logic [BB-1:0]    core_ll_o;
  logic             core_ready_i;
  logic             core_h_v_i;
  logic [7:0]       core_h_i;
  logic             h_v_o;
  logic [7:0]       h_o;
  logic             h_last_o;
  logic             busy_o;

  modport slave (
    input  cfg_v_i, cfg_kk_i, cfg_nn_i, cfg_ll_i, s_v_i, s_data_i,
           core_ready_i, core_h_v_i, core_h_i,
    output cfg_ready_o, s_ready_o, core_data_v_o, core_data_idx_o, core_data_o,
           core_first_o, core_last_o, core_kk_o, core_nn_o, core_ll_o,
           h_v_o, h_o, h_last_o, busy_o
  );

  modport master (
    output cfg_v_i, cfg_kk_i, cfg_nn_i, cfg_ll_i, s_v_i, s_data_i,
           core_ready_i, core_h_v_i, core_h_i,
    input  cfg_ready_o, s_ready_o, core_data_v_o, core_data_idx_o, core_data_o,
           core_first_o, core_last_o, core_kk_o, core_nn_o, core_ll_o,
           h_v_o, h_o, h_last_o, busy_o
  );
endinterface

// File: rtl/blake2_msg_sched.sv
// Blake2 message scheduler: cuts key/message bytes into zero-padded BB-byte blocks for the
// compression core, sequences block flags, and trims the core's result burst to nn digest bytes.
module blake2_msg_sched #(
  parameter int W    = 32,
  parameter int BB   = W*2,
  parameter int KK_W = $clog2(W+1)
) (
  input  logic              clk,
  input  logic              nreset,
  blake2_msg_sched_if.slave bus
);
  localparam int               IDX_W    = $clog2(BB);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BB-1);

  typedef enum logic [2:0] {IDLE, KEY, MSG, PAD, WAIT_F, RES} state_t;

  typedef struct packed {
    logic [KK_W-1:0] kk;
    logic [KK_W-1:0] nn;
    logic [BB-1:0]   ll_tot;
  } cfg_t;

  state_t           state;
  cfg_t             cfg;
  logic [BB-1:0]    rem;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_nxt;
  logic [KK_W-1:0]  hcnt;
  logic             first_q, last_q;
  logic             seen_low, dropped;
  logic             cfg_rdy_q;
  logic             h_v_q, h_last_q;
  logic [7:0]       h_q;
  logic             in_stream, push, key_done;

  // Core-facing push path is combinational so a byte never waits an extra cycle on core_ready_i.
  always_comb begin
    in_stream         = (state == KEY) || (state == MSG);
    bus.s_ready_o     = in_stream & bus.core_ready_i;
    bus.core_data_v_o = in_stream ? (bus.s_v_i & bus.core_ready_i)
                                  : ((state == PAD) & bus.core_ready_i);
    bus.core_data_o   = in_stream ? bus.s_data_i : 8'h00;
    push              = bus.core_data_v_o;
    idx_nxt           = (idx == IDX_LAST) ? '0 : idx + 1'b1;
    key_done          = (32'(idx) + 32'd1) == 32'(cfg.kk);
  end

  assign bus.cfg_ready_o     = cfg_rdy_q;
  assign bus.core_data_idx_o = idx;
  assign bus.core_first_o    = first_q;
  assign bus.core_last_o     = last_q;
  assign bus.core_kk_o       = cfg.kk;
  assign bus.core_nn_o       = cfg.nn;
  assign bus.core_ll_o       = cfg.ll_tot;
  assign bus.h_v_o           = h_v_q;
  assign bus.h_o             = h_q;
  assign bus.h_last_o        = h_last_q;
  assign bus.busy_o          = (state != IDLE);

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state     <= IDLE;
      cfg       <= '0;
      rem       <= '0;
      idx       <= '0;
      hcnt      <= '0;
      first_q   <= 1'b0;
      last_q    <= 1'b0;
      seen_low  <= 1'b0;
      dropped   <= 1'b0;
      cfg_rdy_q <= 1'b0;
      h_v_q     <= 1'b0;
      h_last_q  <= 1'b0;
      h_q       <= 8'h00;
    end else begin
      h_v_q    <= 1'b0;
      h_last_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.cfg_v_i && cfg_rdy_q) begin
            cfg.kk     <= bus.cfg_kk_i;
            cfg.nn     <= bus.cfg_nn_i;
            cfg.ll_tot <= bus.cfg_ll_i + ((bus.cfg_kk_i != '0) ? BB'(BB) : '0);
            rem        <= bus.cfg_ll_i;
            idx        <= '0;
            first_q    <= 1'b1;
            last_q     <= ((bus.cfg_kk_i == '0) && (bus.cfg_ll_i <= BB'(BB))) ||
                          ((bus.cfg_kk_i != '0) && (bus.cfg_ll_i == '0));
            seen_low   <= 1'b0;
            cfg_rdy_q  <= 1'b0;
            // An empty unkeyed message still hashes one all-zero block.
            if (bus.cfg_kk_i != '0)      state <= KEY;
            else if (bus.cfg_ll_i == '0) state <= PAD;
            else                         state <= MSG;
          end else begin
            cfg_rdy_q <= 1'b1;
          end
        end
        KEY: begin
          if (push) begin
            idx <= idx_nxt;
            if (key_done) state <= PAD;
          end
        end
        MSG: begin
          if (push) begin
            idx <= idx_nxt;
            rem <= rem - BB'(1);
            if (idx == IDX_LAST)    state <= WAIT_F;
            else if (rem == BB'(1)) state <= PAD;
          end
        end
        PAD: begin
          if (push) begin
            idx <= idx_nxt;
            if (idx == IDX_LAST) state <= WAIT_F;
          end
        end
        WAIT_F: begin
          // Core drops ready while compressing; its return marks the block as consumed.
          seen_low <= seen_low | ~bus.core_ready_i;
          if (seen_low && bus.core_ready_i) begin
            seen_low <= 1'b0;
            if (last_q) begin
              dropped <= 1'b0;
              hcnt    <= '0;
              state   <= RES;
            end else begin
              first_q <= 1'b0;
              last_q  <= (rem <= BB'(BB));
              idx     <= '0;
              state   <= MSG;
            end
          end
        end
        RES: begin
          if (bus.core_h_v_i) begin
            if (!dropped) begin
              dropped <= 1'b1;
            end else begin
              h_v_q    <= 1'b1;
              h_q      <= bus.core_h_i;
              h_last_q <= (hcnt == cfg.nn - 1'b1);
              hcnt     <= hcnt + 1'b1;
              if (hcnt == cfg.nn - 1'b1) begin
                state     <= IDLE;
                cfg_rdy_q <= 1'b1;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_blake2_msg_sched.sv
// Directed bench for blake2_msg_sched (W=32, BB=64). The bench acts as stream source,
// compression core (ready drop per block, early dummy beat, digest burst) and digest sink.
module tb_blake2_msg_sched;
  localparam int W    = 32;
  localparam int BB   = 64;
  localparam int KK_W = 6;

  localparam logic [255:0] DIG_ABC   = 256'h508c5e8c327c14e2e1a72ba34eeb452f37458b209ed63a294d999b4c86675982;
  localparam logic [255:0] DIG_EMPTY = 256'h69217a3079908094e11121d042354a7c1f55b6482ca1a51e1b250dfd1ed0eef9;
  localparam logic [255:0] DIG_PAT   = {8{32'hc0ffee11}} ^ {32{8'h35}};

  logic clk = 1'b0;
  logic nreset = 1'b0;
  always #5 clk = ~clk;

  blake2_msg_sched_if #(.W(W), .BB(BB), .KK_W(KK_W)) bus ();
  blake2_msg_sched #(.W(W), .BB(BB), .KK_W(KK_W)) dut (.clk(clk), .nreset(nreset), .bus(bus));

  int pass_cnt = 0;
  int total    = 0;

  logic [7:0] key_b [0:31];
  logic [7:0] msg_b [0:255];
  logic [7:0] exp_b [0:511];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [7:0] dig_byte(input logic [255:0] d, input int i);
    return d[255-8*i -: 8];
  endfunction

  task automatic wait_cfg_ready();
    for (int t = 0; t < 10 && bus.cfg_ready_o !== 1'b1; t++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic run_job(input string nm, input int kk, input int nn, input int ll,
                         input bit rnd, input logic [255:0] dig, input int exp_pad);
    int total_in, base, nblk, pos, blk, bcnt, stall, k, phase, tail;
    int bad_data, bad_idx, bad_flag, bad_ll, pads, hn, bad_h, last_at, nlast;
    logic cur_first, cur_last;
    logic [7:0] eb;
    total_in = kk + ll;
    pos = 0; blk = 0; bcnt = 0; stall = 0; k = -1; phase = 0; tail = 0;
    bad_data = 0; bad_idx = 0; bad_flag = 0; bad_ll = 0; pads = 0;
    hn = 0; bad_h = 0; last_at = -1; nlast = 0;
    cur_first = 1'b0; cur_last = 1'b0;
    for (int i = 0; i < 512; i++) exp_b[i] = 8'h00;
    base = 0;
    if (kk != 0) begin
      for (int i = 0; i < kk; i++) exp_b[i] = key_b[i];
      base = BB;
    end
    for (int i = 0; i < ll; i++) exp_b[base+i] = msg_b[i];
    nblk = (base + ll + BB - 1) / BB;
    if (nblk == 0) nblk = 1;

    wait_cfg_ready();
    chk({nm, " cfg_ready"}, 64'(bus.cfg_ready_o), 64'd1);
    bus.cfg_v_i  = 1'b1;
    bus.cfg_kk_i = KK_W'(kk);
    bus.cfg_nn_i = KK_W'(nn);
    bus.cfg_ll_i = 64'(ll);
    @(posedge clk); #1;
    // Under random mode a competing config is held up during the job; it must be ignored.
    bus.cfg_v_i  = rnd;
    bus.cfg_kk_i = 6'd7;
    bus.cfg_nn_i = 6'd3;
    bus.cfg_ll_i = 64'd999;
    chk({nm, " busy"}, 64'(bus.busy_o), 64'd1);

    for (int cyc = 0; cyc < 4000 && phase != 4; cyc++) begin
      bus.s_v_i      = (pos < total_in) && (!rnd || $urandom_range(0, 2) != 0);
      bus.s_data_i   = (pos < kk) ? key_b[pos] : ((pos < total_in) ? msg_b[pos-kk] : 8'h00);
      bus.core_h_v_i = 1'b0;
      bus.core_h_i   = 8'h00;
      if (phase == 0) begin
        bus.core_ready_i = !rnd || ($urandom_range(0, 3) != 0);
      end else if (phase == 1) begin
        bus.core_ready_i = 1'b0;
        stall--;
        if (stall == 0) phase = (blk >= nblk) ? 2 : 0;
      end else if (phase == 2) begin
        bus.core_ready_i = 1'b1;
        bus.cfg_v_i      = 1'b0;
        if (k > 32) begin
          phase = 3;
        end else if (k < 0) begin
          k++;
        end else if (!rnd || $urandom_range(0, 2) != 0) begin
          bus.core_h_v_i = 1'b1;
          bus.core_h_i   = (k == 0) ? 8'ha5 : dig_byte(dig, k - 1);
          k++;
        end
      end else begin
        bus.core_ready_i = 1'b1;
        tail++;
        if (tail >= 4) phase = 4;
      end

      @(negedge clk);
      if (bus.core_data_v_o === 1'b1) begin
        if (bcnt == 0) begin
          cur_first = bus.core_first_o;
          cur_last  = bus.core_last_o;
          if (cur_first !== (blk == 0) || cur_last !== (blk == nblk - 1)) bad_flag++;
        end else if (bus.core_first_o !== cur_first || bus.core_last_o !== cur_last) begin
          bad_flag++;
        end
        if (bus.core_data_idx_o !== 6'(bcnt)) bad_idx++;
        eb = (blk * BB + bcnt < 512) ? exp_b[blk*BB+bcnt] : 8'hxx;
        if (bus.core_data_o !== eb) bad_data++;
        if (bus.s_ready_o !== 1'b1) pads++;
        if (bus.core_ll_o !== 64'(ll + base)) bad_ll++;
        bcnt++;
        if (bcnt == BB) begin
          bcnt  = 0;
          blk++;
          stall = 3;
          phase = 1;
        end
      end
      if (bus.s_v_i && bus.s_ready_o === 1'b1) pos++;
      if (bus.h_v_o === 1'b1) begin
        if (hn >= 32 || bus.h_o !== dig_byte(dig, hn)) bad_h++;
        hn++;
        if (bus.h_last_o === 1'b1) begin
          last_at = hn;
          nlast++;
        end
      end
      @(posedge clk); #1;
    end
    bus.cfg_v_i = 1'b0;

    chk({nm, " finished"}, 64'(phase), 64'd4);
    chk({nm, " blocks"}, 64'(blk), 64'(nblk));
    chk({nm, " partial_block"}, 64'(bcnt), 64'd0);
    chk({nm, " stream_taken"}, 64'(pos), 64'(total_in));
    chk({nm, " data_err"}, 64'(bad_data), 64'd0);
    chk({nm, " idx_err"}, 64'(bad_idx), 64'd0);
    chk({nm, " flag_err"}, 64'(bad_flag), 64'd0);
    chk({nm, " ll_err"}, 64'(bad_ll), 64'd0);
    chk({nm, " pad_bytes"}, 64'(pads), 64'(exp_pad));
    chk({nm, " digest_len"}, 64'(hn), 64'(nn));
    chk({nm, " digest_err"}, 64'(bad_h), 64'd0);
    chk({nm, " last_pos"}, 64'(last_at), 64'(nn));
    chk({nm, " last_cnt"}, 64'(nlast), 64'd1);
    chk({nm, " kk_held"}, 64'(bus.core_kk_o), 64'(kk));
    chk({nm, " idle"}, 64'(bus.busy_o), 64'd0);
  endtask

  initial begin
    bus.cfg_v_i      = 1'b0;
    bus.cfg_kk_i     = '0;
    bus.cfg_nn_i     = '0;
    bus.cfg_ll_i     = '0;
    bus.s_v_i        = 1'b1;
    bus.s_data_i     = 8'h5a;
    bus.core_ready_i = 1'b1;
    bus.core_h_v_i   = 1'b1;
    bus.core_h_i     = 8'h77;
    for (int i = 0; i < 32; i++)  key_b[i] = 8'(i);
    for (int i = 0; i < 256; i++) msg_b[i] = 8'(i * 3 + 5);

    #12;
    chk("reset outputs", 64'({bus.cfg_ready_o, bus.s_ready_o, bus.core_data_v_o, bus.core_data_idx_o,
                              bus.core_data_o, bus.core_first_o, bus.core_last_o, bus.core_kk_o,
                              bus.core_nn_o, bus.h_v_o, bus.h_o, bus.h_last_o, bus.busy_o}), 64'd0);
    chk("reset ll", bus.core_ll_o, 64'd0);
    bus.s_v_i = 1'b0;
    bus.core_h_v_i = 1'b0;
    @(posedge clk); #1;
    nreset = 1'b1;

    // 1: "abc" unkeyed
    msg_b[0] = 8'h61; msg_b[1] = 8'h62; msg_b[2] = 8'h63;
    run_job("abc", 0, 32, 3, 1'b0, DIG_ABC, 61);
    // 2: empty unkeyed
    run_job("empty", 0, 32, 0, 1'b0, DIG_EMPTY, 64);
    // 3: exact block, one over
    for (int i = 0; i < 256; i++) msg_b[i] = 8'(i * 3 + 5);
    run_job("ll64", 0, 32, 64, 1'b0, DIG_PAT, 0);
    run_job("ll65", 0, 32, 65, 1'b0, DIG_PAT, 63);
    // 4: keyed
    run_job("key_ll0", 32, 32, 0, 1'b0, DIG_PAT, 32);
    run_job("key_ll1", 32, 32, 1, 1'b0, DIG_PAT, 95);
    run_job("key16_nn20", 16, 20, 10, 1'b0, DIG_ABC, 102);
    // 5: random gaps on stream, core ready and result beats
    for (int i = 0; i < 256; i++) msg_b[i] = 8'($urandom);
    run_job("random", 0, 32, 150, 1'b1, DIG_PAT, 42);
    run_job("random_key", 16, 32, 70, 1'b1, DIG_EMPTY, 106);

    // 6: abort mid-message, then the abc job must come out intact
    msg_b[0] = 8'h61; msg_b[1] = 8'h62; msg_b[2] = 8'h63;
    wait_cfg_ready();
    bus.cfg_v_i  = 1'b1;
    bus.cfg_kk_i = 6'd0;
    bus.cfg_nn_i = 6'd32;
    bus.cfg_ll_i = 64'd3;
    @(posedge clk); #1;
    bus.cfg_v_i      = 1'b0;
    bus.core_ready_i = 1'b1;
    bus.s_v_i        = 1'b1;
    bus.s_data_i     = 8'h61;
    @(posedge clk); #1;
    bus.s_data_i = 8'h62;
    @(posedge clk); #1;
    bus.s_v_i = 1'b1;
    bus.s_data_i = 8'h63;
    chk("abort mid idx", 64'(bus.core_data_idx_o), 64'd2);
    nreset = 1'b0;
    #1;
    chk("abort outputs", 64'({bus.cfg_ready_o, bus.s_ready_o, bus.core_data_v_o, bus.core_data_idx_o,
                              bus.core_data_o, bus.core_first_o, bus.core_last_o, bus.core_kk_o,
                              bus.core_nn_o, bus.h_v_o, bus.h_o, bus.h_last_o, bus.busy_o}), 64'd0);
    chk("abort ll", bus.core_ll_o, 64'd0);
    bus.s_v_i = 1'b0;
    @(posedge clk); #1;
    nreset = 1'b1;
    run_job("abc_after_abort", 0, 32, 3, 1'b0, DIG_ABC, 61);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
